// File: rtl/s100_io_port_responder_pkg.sv
// Shared types and helpers for the S100 I/O port responder.
package s100_io_port_responder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        RD_WAIT,
        RD_HOLD,
        RELEASE
    } state_t;

    localparam logic [7:0] DEFAULT_PORT_BASE = 8'hC0;

    // Port index width, never narrower than one bit.
    function automatic int idx_w(input int num_ports);
        return (num_ports <= 2) ? 1 : $clog2(num_ports);
    endfunction

endpackage

// File: rtl/s100_sync_bit.sv
// Multi-flop synchronizer for one asynchronous bus strobe, with selectable reset level.
module s100_sync_bit #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/s100_io_port_responder.sv
// S100 bus-side I/O port responder: decodes IN/OUT cycles to a small port bank
// and holds pRDY low for a fixed number of clocks per accepted cycle.
module s100_io_port_responder
    import s100_io_port_responder_pkg::*;
#(
    parameter logic [7:0] PORT_BASE   = DEFAULT_PORT_BASE,
    parameter int         NUM_PORTS   = 4,
    parameter int         WAIT_CYCLES = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                           pll0_250MHz,
    input  logic                           reset,
    input  logic [15:0]                    busAdr,
    input  logic                           sOUT,
    input  logic                           sINP,
    input  logic                           pWR_n,
    input  logic                           pDBIN,
    input  logic [7:0]                     busDO,
    output logic [7:0]                     busDI,
    output logic                           diEnable,
    output logic                           pRDY,
    output logic [idx_w(NUM_PORTS)-1:0]    portWrIndex,
    output logic [7:0]                     portWrData,
    output logic                           portWrStrobe,
    output logic [idx_w(NUM_PORTS)-1:0]    portRdIndex,
    input  logic [8*NUM_PORTS-1:0]         portRdData,
    output logic                           portRdStrobe
);

    localparam int         IW        = idx_w(NUM_PORTS);
    localparam logic [7:0] IDX_MASK  = 8'(NUM_PORTS - 1);
    localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

    logic s_out_s, s_inp_s, wr_n_s, dbin_s;

    s100_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sout (
        .clk(pll0_250MHz), .rst(reset), .d(sOUT),  .q(s_out_s));
    s100_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sinp (
        .clk(pll0_250MHz), .rst(reset), .d(sINP),  .q(s_inp_s));
    s100_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_wr_n (
        .clk(pll0_250MHz), .rst(reset), .d(pWR_n), .q(wr_n_s));
    s100_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_dbin (
        .clk(pll0_250MHz), .rst(reset), .d(pDBIN), .q(dbin_s));

    // Address and write data are stable whenever a synchronized strobe is active,
    // so they are used directly without synchronizers.
    logic          match;
    logic [IW-1:0] addr_idx;
    logic [7:0]    rd_byte;
    logic          wr_req, rd_req;

    assign match    = (busAdr[15:8] == 8'h00) && ((busAdr[7:0] & ~IDX_MASK) == PORT_BASE);
    assign addr_idx = (NUM_PORTS == 1) ? '0 : busAdr[IW-1:0];
    assign wr_req   = s_out_s && !s_inp_s && !wr_n_s && match;
    assign rd_req   = s_inp_s && !s_out_s && dbin_s && match;

    always_comb begin
        rd_byte = 8'h00;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (addr_idx == IW'(k)) begin
                rd_byte = portRdData[8*k +: 8];
            end
        end
    end

    state_t     state;
    logic [7:0] cnt;

    always_ff @(posedge pll0_250MHz or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            busDI        <= 8'h00;
            diEnable     <= 1'b0;
            pRDY         <= 1'b1;
            portWrIndex  <= '0;
            portWrData   <= 8'h00;
            portWrStrobe <= 1'b0;
            portRdIndex  <= '0;
            portRdStrobe <= 1'b0;
        end else begin
            portWrStrobe <= 1'b0;
            portRdStrobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_req) begin
                        portWrData   <= busDO;
                        portWrIndex  <= addr_idx;
                        portWrStrobe <= 1'b1;
                        pRDY         <= 1'b0;
                        cnt          <= WAIT_INIT;
                        state        <= WR_WAIT;
                    end else if (rd_req) begin
                        portRdIndex  <= addr_idx;
                        busDI        <= rd_byte;
                        portRdStrobe <= 1'b1;
                        diEnable     <= 1'b1;
                        pRDY         <= 1'b0;
                        cnt          <= WAIT_INIT;
                        state        <= RD_WAIT;
                    end
                end
                // Waits run to completion even if the master drops its strobe early.
                WR_WAIT: begin
                    if (cnt == 8'd1) begin
                        pRDY  <= 1'b1;
                        cnt   <= 8'd0;
                        state <= RELEASE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                RD_WAIT: begin
                    if (cnt == 8'd1) begin
                        pRDY  <= 1'b1;
                        cnt   <= 8'd0;
                        state <= RD_HOLD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                RD_HOLD: begin
                    if (!dbin_s) begin
                        diEnable <= 1'b0;
                        state    <= RELEASE;
                    end
                end
                // Re-arm only once the bus is fully idle: one strobe per bus cycle.
                RELEASE: begin
                    if (wr_n_s && !dbin_s && !s_out_s && !s_inp_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_s100_io_port_responder.sv
// Directed bench for s100_io_port_responder with a queue-based strobe scoreboard.
`timescale 1ns/1ps
module tb_s100_io_port_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] busAdr;
    logic        sOUT, sINP, pWR_n, pDBIN;
    logic [7:0]  busDO;
    logic [7:0]  busDI;
    logic        diEnable, pRDY;
    logic [1:0]  portWrIndex, portRdIndex;
    logic [7:0]  portWrData;
    logic        portWrStrobe, portRdStrobe;
    logic [31:0] portRdData;

    always #5 clk = ~clk;

    s100_io_port_responder dut (
        .pll0_250MHz (clk),
        .reset       (reset),
        .busAdr      (busAdr),
        .sOUT        (sOUT),
        .sINP        (sINP),
        .pWR_n       (pWR_n),
        .pDBIN       (pDBIN),
        .busDO       (busDO),
        .busDI       (busDI),
        .diEnable    (diEnable),
        .pRDY        (pRDY),
        .portWrIndex (portWrIndex),
        .portWrData  (portWrData),
        .portWrStrobe(portWrStrobe),
        .portRdIndex (portRdIndex),
        .portRdData  (portRdData),
        .portRdStrobe(portRdStrobe)
    );

    typedef struct {
        bit         is_wr;
        logic [1:0] idx;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic push_exp(input bit is_wr, input logic [1:0] idx, input logic [7:0] data);
        exp_t e;
        e.is_wr = is_wr;
        e.idx   = idx;
        e.data  = data;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every strobe must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (portWrStrobe) begin
                if (exp_q.size() == 0 || !exp_q[0].is_wr) begin
                    total++;
                    $display("FAIL unexpected_wr_strobe: got index %0h data %0h", portWrIndex, portWrData);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_index", 32'(portWrIndex), 32'(e.idx));
                    check("wr_data", 32'(portWrData), 32'(e.data));
                end
            end
            if (portRdStrobe) begin
                if (exp_q.size() == 0 || exp_q[0].is_wr) begin
                    total++;
                    $display("FAIL unexpected_rd_strobe: got index %0h busDI %0h", portRdIndex, busDI);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_index", 32'(portRdIndex), 32'(e.idx));
                    check("rd_busdi", 32'(busDI), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Per-cycle measurements relative to the strobe assertion.
    int cyc, m_first, m_strobes, m_prdy_low, m_die_first, m_die_drop, rel_cyc;

    task automatic clear_meas();
        cyc = 0; m_first = -1; m_strobes = 0; m_prdy_low = 0;
        m_die_first = -1; m_die_drop = -1; rel_cyc = -1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (portWrStrobe || portRdStrobe) begin
                m_strobes++;
                if (m_first < 0) m_first = cyc;
            end
            if (!pRDY) m_prdy_low++;
            if (diEnable && m_die_first < 0) m_die_first = cyc;
            if (rel_cyc >= 0 && !diEnable && m_die_drop < 0) m_die_drop = cyc - rel_cyc;
        end
    endtask

    task automatic bus_cycle(input bit out_st, input bit inp_st, input bit use_wr,
                             input logic [15:0] adr, input logic [7:0] dout, input int hold);
        @(negedge clk);
        busAdr = adr; busDO = dout; sOUT = out_st; sINP = inp_st;
        repeat (3) @(negedge clk);
        if (use_wr) pWR_n = 1'b0;
        else        pDBIN = 1'b1;
        clear_meas();
        step(hold);
        @(negedge clk);
        pWR_n = 1'b1; pDBIN = 1'b0;
        rel_cyc = cyc;
        step(6);
        @(negedge clk);
        sOUT = 1'b0; sINP = 1'b0;
        step(4);
    endtask

    initial begin
        reset = 1'b1;
        busAdr = 16'h0000; busDO = 8'h00;
        sOUT = 1'b0; sINP = 1'b0; pWR_n = 1'b1; pDBIN = 1'b0;
        portRdData = 32'h33_22_A5_11;
        #12;
        check("reset_busdi", 32'(busDI), 32'h0);
        check("reset_dien", 32'(diEnable), 32'h0);
        check("reset_prdy", 32'(pRDY), 32'h1);
        check("reset_wrdata", 32'(portWrData), 32'h0);
        check("reset_wridx", 32'(portWrIndex), 32'h0);
        check("reset_rdidx", 32'(portRdIndex), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // OUT 0xC2 <- 0x5A
        push_exp(1'b1, 2'd2, 8'h5A);
        bus_cycle(1'b1, 1'b0, 1'b1, 16'h00C2, 8'h5A, 40);
        check("out_latency", 32'(m_first), 32'd3);
        check("out_strobes", 32'(m_strobes), 32'd1);
        check("out_prdy_low", 32'(m_prdy_low), 32'd8);
        check("out_wrdata_hold", 32'(portWrData), 32'h5A);
        check("out_wridx_hold", 32'(portWrIndex), 32'd2);

        // IN 0xC1 -> 0xA5
        push_exp(1'b0, 2'd1, 8'hA5);
        bus_cycle(1'b0, 1'b1, 1'b0, 16'h00C1, 8'h00, 30);
        check("in_latency", 32'(m_first), 32'd3);
        check("in_die_first", 32'(m_die_first), 32'd3);
        check("in_strobes", 32'(m_strobes), 32'd1);
        check("in_prdy_low", 32'(m_prdy_low), 32'd8);
        check("in_die_drop_range", 32'(m_die_drop >= 2 && m_die_drop <= 3), 32'd1);
        check("in_busdi_held", 32'(busDI), 32'hA5);

        // Cycles that must be ignored
        bus_cycle(1'b1, 1'b0, 1'b1, 16'h00C4, 8'h77, 20);
        check("nm_c4_strobes", 32'(m_strobes), 32'd0);
        check("nm_c4_prdy", 32'(m_prdy_low), 32'd0);
        bus_cycle(1'b1, 1'b0, 1'b1, 16'h12C0, 8'h78, 20);
        check("nm_hi_strobes", 32'(m_strobes), 32'd0);
        check("nm_hi_prdy", 32'(m_prdy_low), 32'd0);
        bus_cycle(1'b0, 1'b0, 1'b1, 16'h00C0, 8'h79, 20);
        check("nm_mem_strobes", 32'(m_strobes), 32'd0);
        check("nm_mem_prdy", 32'(m_prdy_low), 32'd0);
        bus_cycle(1'b1, 1'b1, 1'b1, 16'h00C0, 8'h7A, 20);
        check("both_strobes", 32'(m_strobes), 32'd0);
        check("both_prdy", 32'(m_prdy_low), 32'd0);
        check("nm_wrdata_kept", 32'(portWrData), 32'h5A);
        check("nm_wridx_kept", 32'(portWrIndex), 32'd2);

        // Reset during RD_WAIT
        push_exp(1'b0, 2'd1, 8'hA5);
        @(negedge clk);
        busAdr = 16'h00C1; sINP = 1'b1;
        repeat (3) @(negedge clk);
        pDBIN = 1'b1;
        clear_meas();
        step(5);
        check("rst_pre_dien", 32'(diEnable), 32'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_async_dien", 32'(diEnable), 32'd0);
        check("rst_async_prdy", 32'(pRDY), 32'd1);
        check("rst_async_busdi", 32'(busDI), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        push_exp(1'b0, 2'd1, 8'hA5);
        clear_meas();
        step(20);
        check("rst_retrig_strobes", 32'(m_strobes), 32'd1);
        check("rst_retrig_prdy", 32'(m_prdy_low), 32'd8);
        @(negedge clk);
        pDBIN = 1'b0;
        step(6);
        @(negedge clk);
        sINP = 1'b0;
        step(4);

        // Back-to-back OUTs separated by a single idle clock
        push_exp(1'b1, 2'd0, 8'h11);
        push_exp(1'b1, 2'd3, 8'h22);
        @(negedge clk);
        busAdr = 16'h00C0; busDO = 8'h11; sOUT = 1'b1;
        repeat (3) @(negedge clk);
        pWR_n = 1'b0;
        clear_meas();
        step(14);
        @(negedge clk);
        pWR_n = 1'b1; sOUT = 1'b0; busAdr = 16'h00C3; busDO = 8'h22;
        @(negedge clk);
        pWR_n = 1'b0; sOUT = 1'b1;
        step(16);
        check("b2b_strobes", 32'(m_strobes), 32'd2);
        check("b2b_prdy_low", 32'(m_prdy_low), 32'd16);
        check("b2b_wrdata", 32'(portWrData), 32'h22);
        check("b2b_wridx", 32'(portWrIndex), 32'd3);
        @(negedge clk);
        pWR_n = 1'b1; sOUT = 1'b0;
        step(6);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
